game_state_ctrl: RTL and testbench

Top-level game sequencer for the Quidditch VGA design. Owns the IDLE/PLAYING/GAME-OVER life cycle and drives `playing_reg`, which gates the game-over overlay and freezes the play logic. Counts the match clock in frames from the VGA refresh tick and ends the match on timeout or on a score-logic end event. Blinks the game-over overlay and enforces a minimum display time before a restart is accepted.

---
 rtl/game_state_ctrl.sv | 146 ++++++++++++++
 tb/tb_game_state_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// -----------------------------------------------------------------------------
// game_state_ctrl
//   Match sequencer for the Quidditch VGA game. Runs the IDLE -> START ->
//   PLAYING -> OVER life cycle. It counts the match clock in frames from the
//   VGA refresh tick. A match ends on timeout or on a score-logic end event.
//   In OVER it blinks the game-over overlay and enforces a minimum display
//   time before a restart is accepted.
//
// Ports
//   clk            system/pixel clock (single domain)
//   reset          synchronous, active-high reset
//   refr_tick      one-cycle pulse per frame (start of vertical retrace)
//   btn_start      debounced start button level; only rising edges are used
//   end_game       one-cycle end-of-match pulse from the score logic
//   playing_reg    high while a match is running
//   gameover_show  game-over overlay enable, frame-stable while blinking
//   clear_scores   one-cycle pulse that zeroes the score counters
//   time_left      seconds remaining in the match
// -----------------------------------------------------------------------------
module game_state_ctrl #(
   parameter int unsigned GAME_SECONDS   = 60,
   parameter int unsigned FRAMES_PER_SEC = 60,
   parameter int unsigned BLINK_FRAMES   = 30,
   parameter int unsigned HOLD_FRAMES    = 120
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       refr_tick,
   input  logic       btn_start,
   input  logic       end_game,
   output logic       playing_reg,
   output logic       gameover_show,
   output logic       clear_scores,
   output logic [6:0] time_left
);

   typedef enum logic [1:0] {IDLE, START, PLAYING, OVER} state_t;

   localparam logic [6:0] GAME_TIME  = 7'(GAME_SECONDS);
   localparam logic [5:0] FRAME_LAST = 6'(FRAMES_PER_SEC - 1);
   localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
   localparam logic [7:0] HOLD_MAX   = 8'(HOLD_FRAMES);

   state_t     state;
   logic       btn_d;
   logic [5:0] frame_cnt;
   logic [7:0] hold_cnt;
   logic [7:0] blink_cnt;
   logic       blink_ph;
   logic       start_rise;

   assign start_rise = btn_start & ~btn_d;

   always_ff @(posedge clk) begin
      // NOTE: all state uses non-blocking assignments so every register in
      // this block sees the values from before the edge, whatever the order.
      //
      // btn_d keeps tracking the button while reset is held. This way a button
      // that is already down when reset is released does not count as a fresh
      // press. The button must be released and pressed again to start.
      btn_d <= btn_start;

      if (reset) begin
         state         <= IDLE;
         playing_reg   <= 1'b0;
         gameover_show <= 1'b0;
         clear_scores  <= 1'b0;
         time_left     <= GAME_TIME;
         frame_cnt     <= '0;
         hold_cnt      <= '0;
         blink_cnt     <= '0;
         blink_ph      <= 1'b0;
      end else begin
         // clear_scores is a pulse. It is only raised on the edge that enters START.
         clear_scores <= 1'b0;

         unique case (state)
            IDLE: begin
               if (start_rise) begin
                  state        <= START;
                  clear_scores <= 1'b1;
               end
            end

            START: begin
               time_left   <= GAME_TIME;
               frame_cnt   <= '0;
               playing_reg <= 1'b1;
               state       <= PLAYING;
            end

            PLAYING: begin
               // end_game wins over a coincident tick, so the clock freezes as-is.
               if (end_game) begin
                  state         <= OVER;
                  playing_reg   <= 1'b0;
                  gameover_show <= 1'b1;
                  blink_ph      <= 1'b1;
                  hold_cnt      <= '0;
                  blink_cnt     <= '0;
               end else if (refr_tick) begin
                  if (frame_cnt == FRAME_LAST) begin
                     frame_cnt <= '0;
                     time_left <= time_left - 7'd1;
                     // The last second ends here, so time_left never wraps below 0.
                     if (time_left == 7'd1) begin
                        state         <= OVER;
                        playing_reg   <= 1'b0;
                        gameover_show <= 1'b1;
                        blink_ph      <= 1'b1;
                        hold_cnt      <= '0;
                        blink_cnt     <= '0;
                     end
                  end else begin
                     frame_cnt <= frame_cnt + 6'd1;
                  end
               end
            end

            OVER: begin
               if (refr_tick) begin
                  if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 8'd1;
                  // The overlay only changes on a frame tick, so it never tears mid-frame.
                  if (blink_cnt == BLINK_LAST) begin
                     blink_cnt     <= '0;
                     blink_ph      <= ~blink_ph;
                     gameover_show <= ~blink_ph;
                  end else begin
                     blink_cnt <= blink_cnt + 8'd1;
                  end
               end
               // A restart needs a fresh press after the minimum display time.
               // This assignment is last, so it overrides a blink update on the same edge.
               if (start_rise && hold_cnt == HOLD_MAX) begin
                  state         <= START;
                  clear_scores  <= 1'b1;
                  gameover_show <= 1'b0;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_game_state_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_state_ctrl
//   Directed bench for game_state_ctrl with short parameters:
//   3 s match, 4 frames/s, 2-frame blink half-period, 4-frame hold.
//   A frame tick is issued every 10 clocks.
// -----------------------------------------------------------------------------
module tb_game_state_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       refr_tick;
   logic       btn_start;
   logic       end_game;
   logic       playing_reg;
   logic       gameover_show;
   logic       clear_scores;
   logic [6:0] time_left;

   int n_cmp = 0;
   int n_err = 0;

   game_state_ctrl #(
      .GAME_SECONDS  (3),
      .FRAMES_PER_SEC(4),
      .BLINK_FRAMES  (2),
      .HOLD_FRAMES   (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .refr_tick    (refr_tick),
      .btn_start    (btn_start),
      .end_game     (end_game),
      .playing_reg  (playing_reg),
      .gameover_show(gameover_show),
      .clear_scores (clear_scores),
      .time_left    (time_left)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance n clock edges; sample and drive 1 time unit after each edge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Wait 9 idle clocks, then run one tick cycle (with optional end_game).
   // The task returns right after the tick edge.
   task automatic frame(input logic eg);
      cyc(9);
      refr_tick = 1'b1;
      end_game  = eg;
      cyc(1);
      refr_tick = 1'b0;
      end_game  = 1'b0;
   endtask

   task automatic press();
      btn_start = 1'b0;
      cyc(1);
      btn_start = 1'b1;
      cyc(1);
   endtask

   // Expected overlay after each OVER tick (half-period of 2 frames).
   int blink_exp [6] = '{1, 0, 0, 1, 1, 0};

   initial begin
      reset     = 1'b1;
      refr_tick = 1'b0;
      btn_start = 1'b1;   // held through reset
      end_game  = 1'b0;
      cyc(2);
      reset = 1'b0;
      check("rst_playing", playing_reg, 0);
      check("rst_show", gameover_show, 0);
      check("rst_clear", clear_scores, 0);
      check("rst_time", time_left, 3);

      // A button held since reset must not start a match.
      cyc(5);
      check("held_no_start", playing_reg, 0);
      check("held_no_clear", clear_scores, 0);

      // Fresh press: the START cycle, then PLAYING.
      press();
      check("start_clear", clear_scores, 1);
      check("start_playing", playing_reg, 0);
      cyc(1);
      btn_start = 1'b0;
      check("play_clear_off", clear_scores, 0);
      check("play_playing", playing_reg, 1);
      check("play_time", time_left, 3);
      check("play_show", gameover_show, 0);

      // Match clock countdown.
      repeat (3) frame(1'b0);
      check("t3_time", time_left, 3);
      frame(1'b0);
      check("t4_time", time_left, 2);

      // A start press during PLAYING has no effect.
      press();
      btn_start = 1'b0;
      check("play_press_playing", playing_reg, 1);
      check("play_press_clear", clear_scores, 0);

      repeat (4) frame(1'b0);
      check("t8_time", time_left, 1);
      repeat (3) frame(1'b0);
      check("t11_time", time_left, 1);
      check("t11_playing", playing_reg, 1);
      frame(1'b0);
      check("t12_time", time_left, 0);
      check("t12_playing", playing_reg, 0);
      check("t12_show", gameover_show, 1);

      // OVER: blink pattern. Presses before the hold expires are ignored.
      // The press at tick 3 is then held through the end of the hold.
      for (int i = 0; i < 6; i++) begin
         frame(1'b0);
         check($sformatf("blink_%0d", i + 1), gameover_show, blink_exp[i]);
         if (i == 0) begin
            end_game = 1'b1;
            cyc(1);
            end_game = 1'b0;
            check("over_endgame_playing", playing_reg, 0);
         end
         if (i == 1) begin
            press();
            btn_start = 1'b0;
            check("early_press_clear", clear_scores, 0);
         end
         if (i == 2) begin
            press();           // stays held
            check("hold3_press_clear", clear_scores, 0);
         end
      end
      cyc(2);
      check("held_over_playing", playing_reg, 0);
      check("held_over_clear", clear_scores, 0);
      check("over_time", time_left, 0);

      // Release and press again: the restart is accepted.
      press();
      check("restart_clear", clear_scores, 1);
      cyc(1);
      btn_start = 1'b0;
      check("restart_clear_off", clear_scores, 0);
      check("restart_playing", playing_reg, 1);
      check("restart_time", time_left, 3);
      check("restart_show", gameover_show, 0);

      // end_game coincides with a wrapping tick at time_left = 2.
      repeat (4) frame(1'b0);
      check("m2_t4_time", time_left, 2);
      repeat (3) frame(1'b0);
      frame(1'b1);
      check("eg_time", time_left, 2);
      check("eg_playing", playing_reg, 0);
      check("eg_show", gameover_show, 1);

      // Restart, then reset mid-match at time_left = 1.
      repeat (4) frame(1'b0);
      press();
      cyc(1);
      btn_start = 1'b0;
      check("m3_playing", playing_reg, 1);
      repeat (8) frame(1'b0);
      check("m3_time", time_left, 1);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      check("abort_playing", playing_reg, 0);
      check("abort_time", time_left, 3);
      check("abort_clear", clear_scores, 0);
      check("abort_show", gameover_show, 0);

      // end_game in IDLE is ignored.
      end_game = 1'b1;
      cyc(1);
      end_game = 1'b0;
      cyc(3);
      check("idle_eg_playing", playing_reg, 0);
      check("idle_eg_show", gameover_show, 0);
      check("idle_eg_clear", clear_scores, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
